hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- MEM_TIMEOUT, 15: maximum data-memory wait cycles.
- CNT_W, 16: stall-counter width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge.
- rst, in, 1: reset, asynchronous, active-low.
- id_rs / id_rt, in, 5: source registers of the instruction in ID.
- id_uses_rt, in, 1: the ID instruction reads rt.
- ex_rd, in, 5: destination register of the instruction in EX.
- ex_memread, in, 1: the EX instruction is a load.
- branch_taken, in, 1: branch resolved taken in ID.
- mem_req, in, 1: the MEM-stage instruction accesses data memory.
- mem_ready, in, 1: data memory access completes this cycle.
- pc_write, out, 1: PC write enable.
- if_id_write, out, 1: IF/ID register write enable.
- if_id_flush, out, 1: zero the IF/ID register.
- id_ex_bubble, out, 1: load a NOP into ID/EX.
- pipe_hold, out, 1: freeze ID/EX, EX/M and M/WB.
- mem_err, out, 1: memory timeout, sticky.
- stall_cnt, out, CNT_W: count of stall cycles.

Function
REQ-003 FSM states SHALL be RUN, MEMWAIT and ERR; the state and the wait counter wcnt SHALL be the only registers besides stall_cnt and mem_err.
REQ-004 In RUN with mem_req=1 and mem_ready=0, the outputs SHALL be pc_write=0, if_id_write=0 and pipe_hold=1 in the same cycle, with next state MEMWAIT and wcnt=1.
REQ-005 In MEMWAIT, pc_write=0, if_id_write=0 and pipe_hold=1; on mem_ready=1 the block SHALL hold that cycle and return to RUN; otherwise wcnt SHALL increment.
REQ-006 In MEMWAIT with mem_ready=0 and wcnt==MEM_TIMEOUT, the next state SHALL be ERR.
REQ-007 ERR SHALL assert mem_err=1, pc_write=0, if_id_write=0 and pipe_hold=1 until reset.
REQ-008 Load-use hazard SHALL be: ex_memread & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
REQ-009 In RUN with no memory wait and a load-use hazard, the outputs SHALL be pc_write=0, if_id_write=0 and id_ex_bubble=1 for exactly that cycle; this SHALL be combinational, with no state change.
REQ-010 In RUN with no memory wait, no load-use hazard and branch_taken=1, if_id_flush=1 for that cycle.
REQ-011 Priority SHALL be memory wait > load-use > branch; a branch coincident with a stall SHALL be ignored, since ID is held and it re-resolves next cycle.
REQ-012 With no condition active in RUN: pc_write=1, if_id_write=1, all other outputs 0.
REQ-013 id_ex_bubble and if_id_flush SHALL be 0 in MEMWAIT and ERR.
REQ-014 ex_rd==0 SHALL never cause a stall.

Reset
REQ-015 With rst=0: state=RUN, wcnt=0, mem_err=0, stall_cnt=0, pc_write=0, if_id_write=0, all other outputs 0.
REQ-016 Reset asserted mid-MEMWAIT or in ERR SHALL return to RUN asynchronously; normal operation SHALL begin on the first clock edge after release.

Configuration
REQ-017 With HAZARD_PERF_CNT_EN defined, stall_cnt SHALL increment by 1 on every cycle where pc_write=0 outside reset, saturating at all-ones.
REQ-018 Without HAZARD_PERF_CNT_EN, stall_cnt SHALL be constant 0 and no counter register SHALL be synthesized.

Structure
REQ-019 A shared package SHALL hold the FSM state encoding (RUN=0, MEMWAIT=1, ERR=2, 2 bits) and the register-0 constant.
REQ-020 The load-use comparator SHALL be the single sub-module hazard_ld_cmp; the FSM and counters SHALL remain in hazard_unit.

Verification
REQ-021 Load-use: ex_memread=1, ex_rd=5, id_rs=5 -> one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; the next cycle with ex_memread=0 -> pc_write=1.
REQ-022 Register zero: ex_memread=1, ex_rd=0, id_rs=0 -> no stall, pc_write=1.
REQ-023 Rt check: ex_rd=7, id_rt=7, id_uses_rt=0 -> no stall; with id_uses_rt=1 -> bubble.
REQ-024 Memory wait: mem_req=1, mem_ready low for 3 cycles then high -> pipe_hold=1 for 4 cycles, then RUN; with the macro, stall_cnt=4.
REQ-025 Timeout: mem_req=1, mem_ready=0 held -> mem_err=1 after 16 cycles of hold with MEM_TIMEOUT=15; rst=0 then clears it.
REQ-026 Priority: branch_taken=1 with a load-use hazard -> if_id_flush=0 and id_ex_bubble=1; the next cycle with the hazard gone -> if_id_flush=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit.
package hazard_pkg;
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    ERR     = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/hazard_ld_cmp.sv
// Load-use comparator: flags an ID source matching the destination of an in-flight load.
module hazard_ld_cmp
  import hazard_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic [4:0] ex_rd,
  input  logic       ex_memread,
  output logic       hazard
);
  // r0 is hardwired, so a load targeting it never produces a dependency
  assign hazard = ex_memread && (ex_rd != REG_ZERO) &&
                  ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: memory-wait FSM with timeout, load-use stall, branch flush.
// Optional stall counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_hold,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic              ld_hazard;

  hazard_ld_cmp u_ld_cmp (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_rd      (ex_rd),
    .ex_memread (ex_memread),
    .hazard     (ld_hazard)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RUN;
      wcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (state_nxt == ERR) mem_err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt    = state;
    wcnt_nxt     = wcnt;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_hold    = 1'b0;
    unique case (state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          pipe_hold = 1'b1;
          state_nxt = MEMWAIT;
          wcnt_nxt  = WCNT_W'(1);
        end else if (ld_hazard) begin
          id_ex_bubble = 1'b1;
        end else begin
          // a branch seen while ID is held is dropped; it re-resolves next cycle
          pc_write    = 1'b1;
          if_id_write = 1'b1;
          if_id_flush = branch_taken;
        end
      end
      MEMWAIT: begin
        pipe_hold = 1'b1;
        if (mem_ready) begin
          state_nxt = RUN;
          wcnt_nxt  = '0;
        end else if (wcnt == WCNT_W'(MEM_TIMEOUT)) begin
          state_nxt = ERR;
        end else begin
          wcnt_nxt = wcnt + WCNT_W'(1);
        end
      end
      ERR: pipe_hold = 1'b1;
      default: state_nxt = RUN;
    endcase
    // outputs are quiet while reset is held, even though state reads RUN
    if (!rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      pipe_hold    = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              stall_cnt <= '0;
    else if (!pc_write && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  end
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: vector table for RUN-state decode plus wait/timeout sequences.
module tb_hazard_unit;
  localparam int CNT_W = 16;

  logic clk = 1'b0, rst = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic id_uses_rt = 0, ex_memread = 0, branch_taken = 0, mem_req = 0, mem_ready = 0;
  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, mem_err;
  logic [CNT_W-1:0] stall_cnt;

  int n_tests = 0, n_fail = 0;

  hazard_unit #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pc_write),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .pipe_hold(pipe_hold), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // exp / outs order: {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold}
  typedef struct {
    string      name;
    logic [4:0] rs, rt, rd;
    logic       uses_rt, memread, branch, req, rdy;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [4:0] outs();
    return {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_rs = v.rs; id_rt = v.rt; ex_rd = v.rd; id_uses_rt = v.uses_rt;
    ex_memread = v.memread; branch_taken = v.branch; mem_req = v.req; mem_ready = v.rdy;
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; ex_rd = 0; id_uses_rt = 0; ex_memread = 0;
    branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    //         name            rs  rt  rd uses mr  br req rdy  exp
    vecs[0]  = '{"idle",        0,  0,  0, 0,  0,  0, 0,  0, 5'b11000};
    vecs[1]  = '{"ldu_rs",      5,  0,  5, 0,  1,  0, 0,  0, 5'b00010};
    vecs[2]  = '{"ldu_gone",    5,  0,  5, 0,  0,  0, 0,  0, 5'b11000};
    vecs[3]  = '{"reg_zero",    0,  0,  0, 0,  1,  0, 0,  0, 5'b11000};
    vecs[4]  = '{"rt_unused",   3,  7,  7, 0,  1,  0, 0,  0, 5'b11000};
    vecs[5]  = '{"rt_used",     3,  7,  7, 1,  1,  0, 0,  0, 5'b00010};
    vecs[6]  = '{"br_vs_ldu",   9,  0,  9, 0,  1,  1, 0,  0, 5'b00010};
    vecs[7]  = '{"br_after",    9,  0,  9, 0,  0,  1, 0,  0, 5'b11100};
    vecs[8]  = '{"mem_hit_br",  1,  2,  3, 1,  0,  1, 1,  1, 5'b11100};
    vecs[9]  = '{"ldu_rt2",     6,  5,  5, 1,  1,  0, 0,  0, 5'b00010};
    vecs[10] = '{"rt_zero",     4,  0,  0, 1,  1,  1, 0,  0, 5'b11100};
    vecs[11] = '{"rd_mismatch", 4,  6,  8, 1,  1,  0, 0,  0, 5'b11000};

    // reset state, with hazard and branch inputs asserted to prove they are masked
    ex_memread = 1; ex_rd = 5; id_rs = 5; branch_taken = 1;
    #7;
    check("reset_outs", outs(), 5'b00000);
    check("reset_err", mem_err, 0);
    check("reset_cnt", stall_cnt, 0);
    idle();
    @(negedge clk); rst = 1'b1;

    foreach (vecs[i]) begin
      next_cycle(); drive(vecs[i]);
      @(negedge clk);
      check(vecs[i].name, outs(), vecs[i].exp);
    end

    // memory wait: ready low 3 cycles, then high -> 4 hold cycles
    next_cycle(); rst = 1'b0; idle();
    #2 rst = 1'b1;
    next_cycle(); mem_req = 1; mem_ready = 0;
    @(negedge clk); check("mw_c1", outs(), 5'b00001);
    next_cycle(); ex_memread = 1; ex_rd = 4; id_rs = 4; branch_taken = 1;
    @(negedge clk); check("mw_c2_masked", outs(), 5'b00001);
    next_cycle(); idle(); mem_req = 1;
    @(negedge clk); check("mw_c3", outs(), 5'b00001);
    next_cycle(); mem_ready = 1;
    @(negedge clk); check("mw_c4_ready", outs(), 5'b00001);
    next_cycle(); idle();
    @(negedge clk); check("mw_back_run", outs(), 5'b11000);
`ifdef HAZARD_PERF_CNT_EN
    check("mw_stall_cnt", stall_cnt, 4);
`else
    check("mw_stall_cnt", stall_cnt, 0);
`endif

    // timeout: 16 hold cycles without error, then sticky mem_err
    next_cycle(); mem_req = 1; mem_ready = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      check($sformatf("to_hold_%0d", c), {outs(), mem_err}, {5'b00001, 1'b0});
      next_cycle();
    end
    @(negedge clk); check("to_err", {outs(), mem_err}, {5'b00001, 1'b1});
    next_cycle(); idle(); mem_ready = 1;
    @(negedge clk); check("err_sticky", {outs(), mem_err}, {5'b00001, 1'b1});
    #2 rst = 1'b0;
    #1 check("err_async_clr", {outs(), mem_err}, {5'b00000, 1'b0});
    @(negedge clk); rst = 1'b1; mem_ready = 0;
    next_cycle();
    @(negedge clk); check("post_reset_run", {outs(), mem_err}, {5'b11000, 1'b0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
